// File: rtl/mmm_pkg.sv
// Shared types and constants for the Montgomery multiplier sequencer.
package mmm_pkg;

  typedef enum logic [5:0] {
    IDLE    = 6'b000001,
    CLEAR   = 6'b000010,
    LOAD    = 6'b000100,
    ITER    = 6'b001000,
    CORRECT = 6'b010000,
    DONE    = 6'b100000
  } mmm_state_e;

  localparam int MMM_WIDTH_DEF = 4;

  // Cycles from the accepting edge to the DONE cycle: clear, load, WIDTH iterations, correct, done.
  function automatic int mmm_latency(input int width);
    return width + 4;
  endfunction

  function automatic int mmm_cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  localparam int MMM_LATENCY = mmm_latency(MMM_WIDTH_DEF);

endpackage

// File: rtl/mmm_iter_cnt.sv
// Bit-index counter for the shift-accumulate phase; wraps to zero after the terminal count.
module mmm_iter_cnt #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc_o  = (cnt_q == CNT_W'(WIDTH - 1));
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = tc_o ? '0 : cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mmm_seq_ctrl.sv
// Sequencer for the bit-serial Montgomery multiplier: clear, load, WIDTH iterations,
// conditional subtraction, done.
module mmm_seq_ctrl
  import mmm_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int CNT_W = mmm_cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic             abort,
  input  logic             ge_n,
  output logic             mmm_en,
  output logic             ld_a,
  output logic             rst_mmm,
  output logic [CNT_W-1:0] bit_idx,
  output logic             sub_sel,
  output logic             busy,
  output logic             done
);

  mmm_state_e state_q;
  mmm_state_e state_d;
  logic       rst_mmm_q;
  logic       abort_s;
  logic       cnt_clr_s;
  logic       cnt_inc_s;
  logic       cnt_tc_s;

  // Abort only means something once an operation is underway.
  assign abort_s   = abort && (state_q != IDLE);
  assign cnt_clr_s = abort_s || ((state_q == CLEAR) && en);
  assign cnt_inc_s = (state_q == ITER) && en && !abort_s;

  mmm_iter_cnt #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr_s),
    .inc_i (cnt_inc_s),
    .cnt_o (bit_idx),
    .tc_o  (cnt_tc_s)
  );

  always_comb begin
    state_d = state_q;
    if (abort_s) begin
      state_d = IDLE;
    end else if (en) begin
      case (state_q)
        IDLE:    state_d = (start && !abort) ? CLEAR : IDLE;
        CLEAR:   state_d = LOAD;
        LOAD:    state_d = ITER;
        ITER:    state_d = cnt_tc_s ? CORRECT : ITER;
        CORRECT: state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rst_mmm_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      rst_mmm_q <= (state_d != CLEAR);
    end
  end

  assign rst_mmm = rst_mmm_q;
  assign mmm_en  = en && (state_q inside {LOAD, ITER, CORRECT});
  assign ld_a    = en && (state_q == LOAD);
  assign sub_sel = (state_q == CORRECT) && ge_n;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);

endmodule

// File: tb/tb_mmm_seq_ctrl.sv
// Self-checking bench for mmm_seq_ctrl: position-in-sequence model plus directed literal checks.
module tb_mmm_seq_ctrl;

  localparam int W = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       ge_n = 1'b0;
  logic       mmm_en;
  logic       ld_a;
  logic       rst_mmm;
  logic [1:0] bit_idx;
  logic       sub_sel;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;
  int p        = 0;  // 0 = idle, else 1-based cycle number within the operation
  int n;

  mmm_seq_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .start   (start),
    .abort   (abort),
    .ge_n    (ge_n),
    .mmm_en  (mmm_en),
    .ld_a    (ld_a),
    .rst_mmm (rst_mmm),
    .bit_idx (bit_idx),
    .sub_sel (sub_sel),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count cycles (current cycle = 1) until done, bounded.
  task automatic wait_done(output int cyc);
    cyc = 1;
    #1;
    while (done !== 1'b1 && cyc < 30) begin
      tick();
      #1;
      cyc++;
    end
  endtask

  // Sequence position model: every cycle of an operation is a step, en=0 freezes it.
  always @(posedge clk or posedge rst) begin
    if (rst) p <= 0;
    else if (abort && p != 0) p <= 0;
    else if (en) begin
      if (p == 0) p <= (start && !abort) ? 1 : 0;
      else if (p == W + 4) p <= 0;
      else p <= p + 1;
    end
  end

  always @(negedge clk) begin
    chk("m_busy",    32'(busy),    32'(p != 0));
    chk("m_done",    32'(done),    32'(p == W + 4));
    chk("m_mmm_en",  32'(mmm_en),  32'(en && p >= 2 && p <= W + 3));
    chk("m_ld_a",    32'(ld_a),    32'(en && p == 2));
    chk("m_bit_idx", 32'(bit_idx), (p >= 3 && p <= W + 2) ? 32'(p - 3) : 32'd0);
    chk("m_sub_sel", 32'(sub_sel), 32'(p == W + 3 && ge_n));
    chk("m_rst_mmm", 32'(rst_mmm), 32'(p != 1));
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rst_mmm", 32'(rst_mmm), 32'd1);
    chk("rst_bit_idx", 32'(bit_idx), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();

    // Basic run, ge_n=1 throughout.
    ge_n = 1'b1; start = 1'b1;
    tick(); start = 1'b0; #1;
    chk("b_c1_rst_mmm", 32'(rst_mmm), 32'd0);
    chk("b_c1_busy", 32'(busy), 32'd1);
    tick(); #1;
    chk("b_c2_ld_a", 32'(ld_a), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      chk("b_iter_idx", 32'(bit_idx), 32'(i));
      chk("b_iter_sub", 32'(sub_sel), 32'd0);
    end
    tick(); #1;
    chk("b_c7_sub_sel", 32'(sub_sel), 32'd1);
    chk("b_c7_done", 32'(done), 32'd0);
    tick(); #1;
    chk("b_c8_done", 32'(done), 32'd1);
    tick(); #1;
    chk("b_c9_done", 32'(done), 32'd0);
    chk("b_c9_busy", 32'(busy), 32'd0);

    // ge_n toggling, low in CORRECT.
    start = 1'b1;
    tick(); start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      ge_n = c[0];
      tick();
    end
    ge_n = 1'b0; #1;
    chk("g_c7_sub_sel", 32'(sub_sel), 32'd0);
    tick(); ge_n = 1'b1; #1;
    chk("g_c8_sub_sel", 32'(sub_sel), 32'd0);
    tick(); tick();

    // Stall 3 cycles at bit_idx=2.
    start = 1'b1;
    tick(); start = 1'b0;
    repeat (4) tick();
    en = 1'b0; #1;
    chk("s_c5_idx", 32'(bit_idx), 32'd2);
    chk("s_c5_mmm_en", 32'(mmm_en), 32'd0);
    tick(); tick(); #1;
    chk("s_c7_idx", 32'(bit_idx), 32'd2);
    tick(); en = 1'b1; #1;
    chk("s_c8_idx", 32'(bit_idx), 32'd2);
    chk("s_c8_mmm_en", 32'(mmm_en), 32'd1);
    tick(); tick(); #1;
    chk("s_c10_done", 32'(done), 32'd0);
    tick(); #1;
    chk("s_c11_done", 32'(done), 32'd1);
    tick(); tick();

    // Abort at bit_idx=1, then restart on the following edge.
    start = 1'b1;
    tick(); start = 1'b0;
    repeat (3) tick();
    abort = 1'b1; #1;
    chk("a_idx1", 32'(bit_idx), 32'd1);
    tick(); abort = 1'b0; start = 1'b1; #1;
    chk("a_busy", 32'(busy), 32'd0);
    chk("a_idx", 32'(bit_idx), 32'd0);
    chk("a_rst_mmm", 32'(rst_mmm), 32'd1);
    tick(); start = 1'b0;
    wait_done(n);
    chk("a_restart_latency", 32'(n), 32'd8);
    tick(); tick();

    // Abort in CLEAR while stalled.
    start = 1'b1;
    tick(); start = 1'b0; en = 1'b0; abort = 1'b1;
    tick(); abort = 1'b0; en = 1'b1; #1;
    chk("ac_busy", 32'(busy), 32'd0);
    chk("ac_rst_mmm", 32'(rst_mmm), 32'd1);

    // Abort together with start in IDLE: ignored.
    abort = 1'b1; start = 1'b1;
    tick(); abort = 1'b0; start = 1'b0; #1;
    chk("ai_busy", 32'(busy), 32'd0);

    // Start held high: back-to-back with one IDLE cycle.
    start = 1'b1;
    tick();
    wait_done(n);
    chk("h_latency", 32'(n), 32'd8);
    tick(); #1;
    chk("h_gap_busy", 32'(busy), 32'd0);
    tick(); #1;
    chk("h_next_busy", 32'(busy), 32'd1);
    chk("h_next_rst_mmm", 32'(rst_mmm), 32'd0);
    start = 1'b0;
    repeat (3) tick();

    // Async reset mid-ITER.
    #2 rst = 1'b1;
    #1;
    chk("r_busy", 32'(busy), 32'd0);
    chk("r_rst_mmm", 32'(rst_mmm), 32'd1);
    chk("r_idx", 32'(bit_idx), 32'd0);
    chk("r_mmm_en", 32'(mmm_en), 32'd0);
    tick(); rst = 1'b0;
    tick(); #1;
    chk("r_idle_busy", 32'(busy), 32'd0);
    chk("r_idle_done", 32'(done), 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
